// File: rtl/data_sram_responder_if.sv
// Request/response bundle between the execute stage (master) and the data SRAM (slave).
// data_ram_err exists only when DATA_RAM_RANGE_CHECK_EN is defined.
interface data_sram_responder_if;
  logic        data_ram_en;
  logic        data_ram_we;
  logic [31:0] data_ram_addr;
  logic [3:0]  data_ram_w_en;
  logic [31:0] data_ram_w_data;
  logic        data_ram_ready;
  logic        data_ram_r_valid;
  logic [31:0] data_ram_r_data;
`ifdef DATA_RAM_RANGE_CHECK_EN
  logic        data_ram_err;

  modport master (
    output data_ram_en, data_ram_we, data_ram_addr, data_ram_w_en, data_ram_w_data,
    input  data_ram_ready, data_ram_r_valid, data_ram_r_data, data_ram_err
  );
  modport slave (
    input  data_ram_en, data_ram_we, data_ram_addr, data_ram_w_en, data_ram_w_data,
    output data_ram_ready, data_ram_r_valid, data_ram_r_data, data_ram_err
  );
`else
  modport master (
    output data_ram_en, data_ram_we, data_ram_addr, data_ram_w_en, data_ram_w_data,
    input  data_ram_ready, data_ram_r_valid, data_ram_r_data
  );
  modport slave (
    input  data_ram_en, data_ram_we, data_ram_addr, data_ram_w_en, data_ram_w_data,
    output data_ram_ready, data_ram_r_valid, data_ram_r_data
  );
`endif
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM with byte-masked writes and RD_LATENCY-cycle reads.
// Optional DATA_RAM_RANGE_CHECK_EN: out-of-range requests are dropped/zeroed and flagged on err.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sram_responder_if.slave io_ram
);

  localparam int unsigned Depth   = 1 << ADDR_WIDTH;
  localparam logic [1:0]  CntInit = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("data_sram_responder: RD_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  r_state;
  logic [1:0]              r_cnt;
  logic                    r_ready;
  logic                    r_valid;
  logic [31:0]             r_data;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd_oor;
  logic                    r_err;
  logic [31:0]             r_mem [Depth];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_accept;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic                    w_oor;
  logic                    w_unused_addr;

  assign w_idx    = io_ram.data_ram_addr[ADDR_WIDTH+1:2];
  assign w_accept = io_ram.data_ram_en & r_ready;
  assign w_rd_acc = w_accept & ~io_ram.data_ram_we;
  assign w_wr_acc = w_accept & io_ram.data_ram_we;

`ifdef DATA_RAM_RANGE_CHECK_EN
  assign w_oor         = |io_ram.data_ram_addr[31:ADDR_WIDTH+2];
  assign w_unused_addr = ^io_ram.data_ram_addr[1:0];
  assign io_ram.data_ram_err = r_err;
`else
  // Upper address bits alias onto the array.
  assign w_oor         = 1'b0;
  assign w_unused_addr = ^{io_ram.data_ram_addr[31:ADDR_WIDTH+2], io_ram.data_ram_addr[1:0],
                           r_err};
`endif

  // Writes commit at their own accept edge, so a later read always sees them.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (io_ram.data_ram_w_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= io_ram.data_ram_w_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 2'd0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= 32'h0;
      r_addr   <= '0;
      r_rd_oor <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_rd_acc) begin
        r_addr   <= w_idx;
        r_rd_oor <= w_oor;
        if (RD_LATENCY == 1) begin
          r_state <= StResp;
          r_ready <= 1'b1;
          r_valid <= 1'b1;
          r_data  <= w_oor ? 32'h0 : r_mem[w_idx];
          r_err   <= w_oor;
        end else begin
          r_state <= StWait;
          r_cnt   <= CntInit;
          r_ready <= 1'b0;
        end
      end else begin
        case (r_state)
          StWait: begin
            if (r_cnt == 2'd0) begin
              r_state <= StResp;
              r_ready <= 1'b1;
              r_valid <= 1'b1;
              r_data  <= r_rd_oor ? 32'h0 : r_mem[r_addr];
              r_err   <= r_rd_oor;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          default: begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        endcase
        // Dropped out-of-range write: one-cycle err pulse after its accept edge.
        if (w_wr_acc && w_oor) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign io_ram.data_ram_ready   = r_ready;
  assign io_ram.data_ram_r_valid = r_valid;
  assign io_ram.data_ram_r_data  = r_data;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: one instance at RD_LATENCY=1 and one at RD_LATENCY=3.
// Read expectations go to per-instance scoreboards stamped with the cycle they are due.
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_sram_responder_if if1();
  data_sram_responder_if if3();

  data_sram_responder #(.ADDR_WIDTH(10), .RD_LATENCY(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .io_ram (if1.slave)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .RD_LATENCY(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .io_ram (if3.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;
  int   ncnt  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  function automatic void cmp_resp(input string name, input exp_t x, input logic [31:0] d,
                                   input logic e);
    chk({name, "_rdata"}, d, x.data);
    chk({name, "_rcycle"}, 32'(ncnt), 32'(x.due));
`ifdef DATA_RAM_RANGE_CHECK_EN
    chk({name, "_err"}, {31'h0, e}, {31'h0, x.err});
`else
    if (e !== 1'b0) chk({name, "_err_absent"}, {31'h0, e}, 32'h0);
`endif
  endfunction

  // Response monitor, sampling at the falling edge.
  always @(negedge clk) begin
    exp_t x;
    logic e1, e3;
    ncnt++;
`ifdef DATA_RAM_RANGE_CHECK_EN
    e1 = if1.data_ram_err;
    e3 = if3.data_ram_err;
`else
    e1 = 1'b0;
    e3 = 1'b0;
`endif
    if (q1.size() > 0 && q1[0].due < ncnt) begin
      total++; bad++;
      $display("FAIL dut1_missing_valid: got none want data %h at cycle %0d", q1[0].data, q1[0].due);
      void'(q1.pop_front());
    end
    if (if1.data_ram_r_valid === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_valid: got r_valid=1 want 0 (data %h)", if1.data_ram_r_data);
      end else begin
        x = q1.pop_front();
        cmp_resp("dut1", x, if1.data_ram_r_data, e1);
      end
    end
    if (q3.size() > 0 && q3[0].due < ncnt) begin
      total++; bad++;
      $display("FAIL dut3_missing_valid: got none want data %h at cycle %0d", q3[0].data, q3[0].due);
      void'(q3.pop_front());
    end
    if (if3.data_ram_r_valid === 1'b1) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL dut3_unexpected_valid: got r_valid=1 want 0 (data %h)", if3.data_ram_r_data);
      end else begin
        x = q3.pop_front();
        cmp_resp("dut3", x, if3.data_ram_r_data, e3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int sel, input logic en, input logic we, input logic [31:0] addr,
                       input logic [3:0] wen, input logic [31:0] wd);
    if (sel == 1) begin
      if1.data_ram_en = en; if1.data_ram_we = we; if1.data_ram_addr = addr;
      if1.data_ram_w_en = wen; if1.data_ram_w_data = wd;
    end else begin
      if3.data_ram_en = en; if3.data_ram_we = we; if3.data_ram_addr = addr;
      if3.data_ram_w_en = wen; if3.data_ram_w_data = wd;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? if1.data_ram_ready : if3.data_ram_ready;
  endfunction

  // Called at posedge+2; holds the request until accepted, returns at posedge+2 after accept.
  task automatic req(input int sel, input logic we, input logic [31:0] addr, input logic [3:0] wen,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     output int stalls);
    exp_t x;
    drive(sel, 1'b1, we, addr, wen, wd);
    stalls = 0;
    while (rdy(sel) !== 1'b1 && stalls < 20) begin
      tick();
      stalls++;
    end
    if (stalls >= 20) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles want 1", stalls);
    end
    if (!we) begin
      x.data = exp_d;
      x.err  = exp_e;
      x.due  = ncnt + 1 + ((sel == 1) ? 1 : 3);
      if (sel == 1) q1.push_back(x);
      else          q3.push_back(x);
    end
    tick();
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_ready1"}, {31'h0, if1.data_ram_ready}, 32'h1);
    chk({name, "_valid1"}, {31'h0, if1.data_ram_r_valid}, 32'h0);
    chk({name, "_rdata1"}, if1.data_ram_r_data, 32'h0);
    chk({name, "_ready3"}, {31'h0, if3.data_ram_ready}, 32'h1);
    chk({name, "_valid3"}, {31'h0, if3.data_ram_r_valid}, 32'h0);
    chk({name, "_rdata3"}, if3.data_ram_r_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[16];
    int   st;
    logic [31:0] alias_exp;

`ifdef DATA_RAM_RANGE_CHECK_EN
    alias_exp = 32'h5566_7788;
`else
    alias_exp = 32'hA5A5_A5A5;
`endif
    vecs[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h11,   4'h2, 32'h0000_5A00, 32'h0};
    vecs[3]  = '{1'b1, 32'h13,   4'h8, 32'hC300_0000, 32'h0};
    vecs[4]  = '{1'b0, 32'h10,   4'h0, 32'h0,         32'hC3AD_5AEF};
    vecs[5]  = '{1'b1, 32'h14,   4'hF, 32'h1122_3344, 32'h0};
    vecs[6]  = '{1'b1, 32'h18,   4'hF, 32'h5566_7788, 32'h0};
    vecs[7]  = '{1'b0, 32'h10,   4'h0, 32'h0,         32'hC3AD_5AEF};
    vecs[8]  = '{1'b0, 32'h14,   4'h0, 32'h0,         32'h1122_3344};
    vecs[9]  = '{1'b0, 32'h1A,   4'h0, 32'h0,         32'h5566_7788};
    vecs[10] = '{1'b1, 32'h14,   4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 32'h14,   4'h0, 32'h0,         32'h1122_3344};
    vecs[12] = '{1'b1, 32'h1018, 4'hF, 32'hA5A5_A5A5, 32'h0};
    vecs[13] = '{1'b0, 32'h18,   4'h0, 32'h0,         alias_exp};
    vecs[14] = '{1'b1, 32'hFFC,  4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[15] = '{1'b0, 32'hFFC,  4'h0, 32'h0,         32'hCAFE_F00D};

    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 reset = 1'b1;
    #1 chk_reset_state("por");
    @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // Back-to-back stream on the single-cycle instance.
    foreach (vecs[i]) begin
      req(1, vecs[i].we, vecs[i].addr, vecs[i].wen, vecs[i].wd, vecs[i].exp, 1'b0, st);
      chk($sformatf("lat1_nostall_%0d", i), 32'(st), 32'h0);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) tick();
    chk("lat1_rdata_hold", if1.data_ram_r_data, 32'hCAFE_F00D);

    // Latency 3: stall accounting, read accepted in RESP, write during RESP.
    req(3, 1'b1, 32'h10, 4'hF, 32'h0BAD_CAFE, 32'h0, 1'b0, st);
    req(3, 1'b1, 32'h14, 4'hF, 32'h1234_5678, 32'h0, 1'b0, st);
    req(3, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0, st);
    chk("lat3_first_read_stall", 32'(st), 32'h0);
    req(3, 1'b0, 32'h14, 4'h0, 32'h0, 32'h1234_5678, 1'b0, st);
    chk("lat3_held_read_stall", 32'(st), 32'h2);
    req(3, 1'b1, 32'h14, 4'h1, 32'h0000_00FF, 32'h0, 1'b0, st);
    chk("lat3_write_stall", 32'(st), 32'h2);
    req(3, 1'b0, 32'h14, 4'h0, 32'h0, 32'h1234_56FF, 1'b0, st);
    chk("lat3_after_write_stall", 32'(st), 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (5) tick();

    // Reset while dut3 waits on a read: that read must never respond.
    req(3, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0, st);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 reset = 1'b1;
    #1 chk_reset_state("midreset");
    q3.delete();
    #1 reset = 1'b0;
    repeat (6) tick();
    req(3, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0BAD_CAFE, 1'b0, st);
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (5) tick();

`ifdef DATA_RAM_RANGE_CHECK_EN
    req(1, 1'b0, 32'h0001_0000, 4'h0, 32'h0, 32'h0, 1'b1, st);
    req(1, 1'b1, 32'h0001_0010, 4'hF, 32'h0, 32'h0, 1'b0, st);
    chk("oor_write_err_pulse", {31'h0, if1.data_ram_err}, 32'h1);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("oor_write_err_clear", {31'h0, if1.data_ram_err}, 32'h0);
    req(1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hC3AD_5AEF, 1'b0, st);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) tick();
`endif

    repeat (6) tick();
    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q3_drained", 32'(q3.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
